uart_rx: RTL and testbench

Serial UART receiver, 8N1 framing, LSB first, one start bit, one stop bit. Sits directly downstream of the UART line driven by the bench's byte/stream/string senders, and upstream of the command parser. Samples each bit at mid-period using a clock-divided bit timer. Presents each received byte as a one-cycle `rx_valid` pulse and flags bad stop bits.

---
 rtl/uart_pkg.sv | 13 +
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;

    // Clock cycles per bit, integer floor.
    function automatic int clks_per_bit(int f, int b);
        return f / b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with a configurable reset value.
module sync_2ff #(
    parameter int unsigned           WIDTH   = 1,
    parameter logic [WIDTH-1:0]      RST_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops to settle the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling from a clock-divided bit timer.
// Optional build macro UART_RX_MAJORITY_EN: each sample is a 2-of-3 vote
// around the nominal sample point, decided one cycle later.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 9600
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_serial,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      frame_err,
    output logic                      rx_busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
`ifdef UART_RX_MAJORITY_EN
    localparam int SMP_OFS = 1;
`else
    localparam int SMP_OFS = 0;
`endif
    localparam int CNT_W = $clog2(CLKS_PER_BIT + SMP_OFS);
    localparam logic [CNT_W-1:0] HALF_TGT   = CNT_W'(CLKS_PER_BIT / 2 - 1 + SMP_OFS);
    localparam logic [CNT_W-1:0] FULL_TGT   = CNT_W'(CLKS_PER_BIT - 1 + SMP_OFS);
    localparam logic [CNT_W-1:0] CNT_RESUME = CNT_W'(SMP_OFS);

    logic                      rx_sync;
    logic                      bit_smp_c;

    uart_rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] sr_q, sr_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      ferr_q, ferr_d;
    logic                      busy_q, busy_d;
    logic                      prev_q, prev_d;
    logic                      armed_q, armed_d;
    logic [1:0]                flush_q, flush_d;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_serial),
        .q   (rx_sync)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // Two-cycle history of the line so the vote sees target-1, target, target+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_sync};
        end
    end

    assign bit_smp_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_sync) | (hist_q[0] & rx_sync);
`else
    assign bit_smp_c = rx_sync;
`endif

    // Next-state and output computation for the receive FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        prev_d  = rx_sync;
        armed_d = armed_q;
        flush_d = flush_q;

        // Edge detection is armed only once the line is seen high after the
        // synchronizer has flushed its reset value, so a line stuck low
        // across reset never starts a frame.
        if (flush_q != 2'd2) begin
            flush_d = flush_q + 2'd1;
        end
        if ((flush_q == 2'd2) && rx_sync) begin
            armed_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (armed_q && prev_q && !rx_sync) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_TGT) begin
                    if (bit_smp_c) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = CNT_RESUME;
                        idx_d   = '0;
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == FULL_TGT) begin
                    sr_d[idx_q] = bit_smp_c;
                    cnt_d       = CNT_RESUME;
                    idx_d       = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == FULL_TGT) begin
                    if (bit_smp_c) begin
                        data_d  = sr_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
            flush_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            flush_q <= flush_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: byte-level line driver plus an event-queue reference.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_FREQ_HZ = 1_000_000;
    localparam int BAUD_RATE   = 100_000;
    localparam int CPB         = CLK_FREQ_HZ / BAUD_RATE;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       rx_serial = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int busy_cycles = 0;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] exp_data = 8'h00;

    uart_rx #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD_RATE   (BAUD_RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_serial (rx_serial),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #500 clk = ~clk;

    // Record every output pulse as {is_frame_err, byte}.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) got_q.push_back({1'b0, rx_data});
            if (frame_err) got_q.push_back({1'b1, 8'h00});
            if (rx_busy) busy_cycles++;
            if (rx_valid || frame_err) begin
                checks++;
                if (rx_valid && frame_err) begin
                    errors++;
                    $display("FAIL valid_ferr_overlap: rx_valid=%0b frame_err=%0b, required not both", rx_valid, frame_err);
                end
            end
        end
    end

    // One 10-bit frame; line is left at the stop value afterwards.
    task automatic send_frame(input logic [7:0] data, input logic stop_val, input int glitch_at);
        for (int c = 0; c < 10 * CPB; c++) begin
            logic v;
            if (c < CPB) v = 1'b0;
            else if (c < 9 * CPB) v = data[3'((c - CPB) / CPB)];
            else v = stop_val;
            if (c == glitch_at) v = ~v;
            @(posedge clk);
            #1 rx_serial = v;
        end
    endtask

    task automatic drive_line(input logic v, input int n);
        repeat (n) begin
            @(posedge clk);
            #1 rx_serial = v;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    endtask

    task automatic test_single;
        got_q.delete();
        send_frame(8'hA5, 1'b1, -1);
        drive_line(1'b1, 30);
        exp_data = 8'hA5;
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
        checks++; if ((got_q.size() > 0 ? got_q[0] : 9'h1FF) !== {1'b0, 8'hA5}) begin errors++; $display("FAIL single_event: got %h want 0a5", got_q.size() > 0 ? got_q[0] : 9'h1FF); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", rx_data); end
        @(negedge clk);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", rx_busy); end
    endtask

    task automatic test_stream;
        logic [7:0] str [3];
        str[0] = 8'h4F; str[1] = 8'h4B; str[2] = 8'h0A;
        got_q.delete();
        for (int i = 0; i < 3; i++) begin
            send_frame(str[i], 1'b1, -1);
            drive_line(1'b1, CPB / 2);
        end
        drive_line(1'b1, 30);
        exp_data = 8'h0A;
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL stream_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            logic [8:0] g;
            g = (i < got_q.size()) ? got_q[i] : 9'h1FF;
            checks++; if (g !== {1'b0, str[i]}) begin errors++; $display("FAIL stream_byte%0d: got %h want %h", i, g, {1'b0, str[i]}); end
        end
    endtask

    task automatic test_glitch;
        got_q.delete();
        busy_cycles = 0;
        drive_line(1'b0, 3);
        drive_line(1'b1, 40);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch_events: got %0d want 0", got_q.size()); end
        checks++; if (busy_cycles < 1 || busy_cycles > 8) begin errors++; $display("FAIL glitch_busy: got %0d cycles want 1..8", busy_cycles); end
    endtask

    task automatic test_frame_err;
        got_q.delete();
        send_frame(8'h3C, 1'b0, -1);
        busy_cycles = 0;
        drive_line(1'b0, 20 * CPB);
        checks++; if (busy_cycles != 0) begin errors++; $display("FAIL ferr_hold_busy: got %0d cycles want 0", busy_cycles); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", got_q.size()); end
        checks++; if ((got_q.size() > 0 ? got_q[0] : 9'h0FF) !== {1'b1, 8'h00}) begin errors++; $display("FAIL ferr_event: got %h want 100", got_q.size() > 0 ? got_q[0] : 9'h0FF); end
        drive_line(1'b1, 30);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL ferr_release: got %0d events want 1", got_q.size()); end
        checks++; if (rx_data !== exp_data) begin errors++; $display("FAIL ferr_data_kept: got %h want %h", rx_data, exp_data); end
        send_frame(8'h5A, 1'b1, -1);
        drive_line(1'b1, 30);
        exp_data = 8'h5A;
        checks++; if ((got_q.size() > 1 ? got_q[1] : 9'h1FF) !== {1'b0, 8'h5A}) begin errors++; $display("FAIL ferr_recover: got %h want 05a", got_q.size() > 1 ? got_q[1] : 9'h1FF); end
    endtask

    task automatic test_reset_mid;
        got_q.delete();
        fork
            send_frame(8'hFF, 1'b1, -1);
            begin
                repeat (5 * CPB + CPB / 2) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
                checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_pulses: got %b%b want 00", rx_valid, frame_err); end
                checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", rx_busy); end
            end
        join
        drive_line(1'b1, 30);
        exp_data = 8'h00;
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rstmid_discard: got %0d events want 0", got_q.size()); end
        send_frame(8'h12, 1'b1, -1);
        drive_line(1'b1, 30);
        exp_data = 8'h12;
        checks++; if ((got_q.size() == 1 ? got_q[0] : 9'h1FF) !== {1'b0, 8'h12}) begin errors++; $display("FAIL rstmid_next: got %h (n=%0d) want 012", got_q.size() > 0 ? got_q[0] : 9'h1FF, got_q.size()); end
        checks++; if (rx_data !== 8'h12) begin errors++; $display("FAIL rstmid_next_data: got %h want 12", rx_data); end
    endtask

    // Random bytes, gaps and stop-bit errors versus an expected event list.
    task automatic test_random;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 24; i++) begin
            logic [7:0] b;
            logic       stop_ok;
            b       = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 5) != 0);
            send_frame(b, stop_ok, -1);
            drive_line(1'b1, $urandom_range(CPB / 2, 2 * CPB + CPB / 2));
            if (stop_ok) begin
                exp_q.push_back({1'b0, b});
                exp_data = b;
            end else begin
                exp_q.push_back({1'b1, 8'h00});
            end
        end
        drive_line(1'b1, 30);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [8:0] g;
            g = (i < got_q.size()) ? got_q[i] : 9'h1FF;
            checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL rand_event%0d: got %h want %h", i, g, exp_q[i]); end
        end
        checks++; if (rx_data !== exp_data) begin errors++; $display("FAIL rand_final_data: got %h want %h", rx_data, exp_data); end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority;
        got_q.delete();
        send_frame(8'h00, 1'b1, CPB / 2 + 3 * CPB);
        drive_line(1'b1, 30);
        checks++; if ((got_q.size() == 1 ? got_q[0] : 9'h1FF) !== {1'b0, 8'h00}) begin errors++; $display("FAIL majority_event: got %h (n=%0d) want 000", got_q.size() > 0 ? got_q[0] : 9'h1FF, got_q.size()); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL majority_data: got %h want 00", rx_data); end
    endtask
`endif

    initial begin
        rx_serial = 1'b1;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset;
        drive_line(1'b1, 5);
        test_single;
        test_stream;
        test_glitch;
        test_frame_err;
        test_reset_mid;
        test_random;
`ifdef UART_RX_MAJORITY_EN
        test_majority;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
